display_driver_row_scanner: RTL
===============================

Name: display_driver_row_scanner

Overview:
Upstream sequencer for the row serial loader. It selects which (row, bit-plane) the pixel pipe fetches next and drives the loader's `load`/`complete` handshake. It also generates the panel-side blank (`oe_n`), `latch` and row-address signals, with binary-coded-modulation (BCM) on-times. Loading of the next row/plane overlaps display of the current one.

Parameters:
rows, 16, panel scan rows; power of two, ≥2
columns, 32, bits per row; informational, passed through to the loader
bit_depth, 4, BCM planes per row; ≥2
base_time, 32, clk cycles `oe_n` is low for plane 0; plane p shows base_time<<p cycles
blank_cycles, 2, cycles `oe_n` is high before `latch`; ≥1

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low (0 = reset)
enable  in  1  run scanning; 0 = stop blanked
load  out  1  to loader: load request
complete  in  1  from loader: one-cycle row-loaded pulse
load_row  out  $clog2(rows)  row the pixel pipe fetches
load_plane  out  $clog2(bit_depth)  plane the pixel pipe fetches
row_addr  out  $clog2(rows)  panel row select (A..D); row currently displayed
latch  out  1  panel latch strobe
oe_n  out  1  panel output enable, active-low
frame_start  out  1  one-cycle pulse when row 0 / plane 0 is latched

Behaviour:
- Reset (rst=0, async), all outputs forced: load=0, latch=0, oe_n=1, row_addr=0, load_row=0, load_plane=0, frame_start=0. Internal state: IDLE, loaded=0, timer=0.
- States: IDLE, RUN, BLANK, LATCH.
- IDLE: oe_n=1, load=0. If enable=1, go to RUN, set load=1, load_row=0, load_plane=0, timer=0 (nothing displayed yet).
- Load handshake in RUN:
  - load stays high until complete=1 is sampled.
  - In that cycle: load<=0, loaded<=1.
  - load_row and load_plane are stable while load=1.
  - complete while load=0 is ignored.
- Display timer in RUN:
  - Decrements by 1 per cycle while nonzero.
  - oe_n=0 while timer>0; oe_n=1 when timer=0.
- Swap: in RUN with loaded=1 and timer=0:
  - enable=1: go to BLANK with counter=blank_cycles.
  - enable=0: go to IDLE; no latch; the loaded data is discarded.
- BLANK: oe_n=1. Counter decrements; go to LATCH when it reaches 1.
- LATCH (exactly one cycle):
  - latch=1, oe_n=1.
  - row_addr<=load_row; shown_plane<=load_plane.
  - frame_start=1 if load_row=0 and load_plane=0.
  - Advance fetch index, plane innermost: load_plane+1; on wrap to 0, load_row+1 (wraps rows-1 → 0).
  - loaded<=0; timer<=base_time<<shown_plane (the plane just latched).
  - Go to RUN with load<=1 on the next cycle.
- Resulting load spacing: load is low for at least 1 cycle between requests, so the loader idles and clears `complete`.
- Exact on-time: oe_n is low for base_time<<p consecutive cycles, starting the cycle after LATCH.
- Slow loader: if complete arrives after timer=0, oe_n stays high (blank) until swap. No row is ever shown without a fresh latch.
- Fast loader: loaded=1 waits for the timer; load stays low.
- enable is sampled only in IDLE and at swap.
- Reset mid-operation: immediate blank (oe_n=1); everything restarts from row 0 / plane 0 after release.
- Timer width: $clog2(base_time<<(bit_depth-1))+1.

Decomposition:
- Shared package display_driver_pkg holds:
  - state enum (IDLE, RUN, BLANK, LATCH);
  - width helper constants ROW_W, PLANE_W, TIMER_W derived from parameters.
- One sub-module: display_driver_bcm_timer. Loadable down-counter with a `busy` output that drives oe_n.

Test Plan:
- Reset/idle: rst=0 mid-run, then released with enable=0 → oe_n=1, load=0, latch=0, row_addr=0 held indefinitely.
- First row: enable=1, model loader pulses complete 40 cycles after load rises → load drops same cycle; oe_n high 2 cycles; latch pulse; row_addr=0; frame_start=1; oe_n low 32 cycles; load re-rises with load_plane=1.
- BCM timing: fast loader (complete after 5 cycles) → oe_n low runs of 32, 64, 128, 256 for planes 0–3 of each row, each separated by 3 high cycles (2 blank + 1 latch).
- Wrap: run past row 15 / plane 3 → next latch sets row_addr=0 with frame_start=1; load_row/load_plane go 15/3 → 0/0.
- Slow loader: complete 300 cycles after load with plane 0 displayed → oe_n stays high from timer expiry until complete + 3 cycles; no extra latch.
- Stop: enable=0 during plane 2 display → swap goes to IDLE without a latch pulse; oe_n=1; load stays 0.

Source files
------------

// File: rtl/display_driver_pkg.sv
// Shared types and width helpers for the display row scanner and its BCM timer.
package display_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_BLANK,
    ST_LATCH
  } state_e;

  localparam int DEF_ROWS      = 16;
  localparam int DEF_BIT_DEPTH = 4;
  localparam int DEF_BASE_TIME = 32;

  // Wide enough to hold the longest on-time, base_time << (bit_depth-1).
  function automatic int timer_width(input int base_time, input int bit_depth);
    return $clog2(base_time << (bit_depth - 1)) + 1;
  endfunction

  localparam int ROW_W   = $clog2(DEF_ROWS);
  localparam int PLANE_W = $clog2(DEF_BIT_DEPTH);
  localparam int TIMER_W = timer_width(DEF_BASE_TIME, DEF_BIT_DEPTH);

endpackage

// File: rtl/display_driver_bcm_timer.sv
// Loadable down-counter; busy_o is high while the loaded on-time is still running.
module display_driver_bcm_timer
  import display_driver_pkg::*;
#(
  parameter int WIDTH = TIMER_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             busy_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy_o = (count_q != '0);

endmodule

// File: rtl/display_driver_row_scanner.sv
// Row/bit-plane sequencer: drives the loader handshake and the panel blank/latch/row
// signals with BCM on-times, overlapping the next row load with the current display.
module display_driver_row_scanner
  import display_driver_pkg::*;
#(
  parameter int ROWS         = 16,
  parameter int COLUMNS      = 32,
  parameter int BIT_DEPTH    = 4,
  parameter int BASE_TIME    = 32,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  output logic                         load,
  input  logic                         complete,
  output logic [$clog2(ROWS)-1:0]      load_row,
  output logic [$clog2(BIT_DEPTH)-1:0] load_plane,
  output logic [$clog2(ROWS)-1:0]      row_addr,
  output logic                         latch,
  output logic                         oe_n,
  output logic                         frame_start
);

  localparam int RB = $clog2(ROWS);
  localparam int PB = $clog2(BIT_DEPTH);
  localparam int TB = timer_width(BASE_TIME, BIT_DEPTH);
  localparam int BB = $clog2(BLANK_CYCLES + 1);
  localparam logic [TB-1:0] BASE_T = TB'(BASE_TIME);

  if ((ROWS < 2) || ((ROWS & (ROWS - 1)) != 0)) begin : g_bad_rows
    $error("ROWS must be a power of two >= 2");
  end
  if (BIT_DEPTH < 2) begin : g_bad_depth
    $error("BIT_DEPTH must be >= 2");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank
    $error("BLANK_CYCLES must be >= 1");
  end
  if (COLUMNS < 1) begin : g_bad_cols
    $error("COLUMNS must be >= 1");
  end

  state_e        state_q, state_d;
  logic          load_q, load_d;
  logic          loaded_q, loaded_d;
  logic [RB-1:0] load_row_q, load_row_d;
  logic [PB-1:0] load_plane_q, load_plane_d;
  logic [RB-1:0] row_addr_q, row_addr_d;
  logic [BB-1:0] blank_q, blank_d;
  logic          timer_load;
  logic [TB-1:0] timer_value;
  logic          timer_busy;

  // The plane being latched sets the on-time of the display that follows.
  assign timer_value = BASE_T << load_plane_q;

  always_comb begin
    state_d      = state_q;
    load_d       = load_q;
    loaded_d     = loaded_q;
    load_row_d   = load_row_q;
    load_plane_d = load_plane_q;
    row_addr_d   = row_addr_q;
    blank_d      = blank_q;
    timer_load   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        load_d = 1'b0;
        if (enable) begin
          state_d      = ST_RUN;
          load_d       = 1'b1;
          loaded_d     = 1'b0;
          load_row_d   = '0;
          load_plane_d = '0;
        end
      end

      ST_RUN: begin
        if (load_q && complete) begin
          load_d   = 1'b0;
          loaded_d = 1'b1;
        end
        // The swap cycle itself is the first blank cycle before the latch.
        if (loaded_q && !timer_busy) begin
          if (enable) begin
            blank_d = BB'(BLANK_CYCLES);
            state_d = (BLANK_CYCLES == 1) ? ST_LATCH : ST_BLANK;
          end else begin
            state_d  = ST_IDLE;
            loaded_d = 1'b0;
          end
        end
      end

      ST_BLANK: begin
        blank_d = blank_q - BB'(1);
        if (blank_d == BB'(1)) begin
          state_d = ST_LATCH;
        end
      end

      ST_LATCH: begin
        row_addr_d = load_row_q;
        timer_load = 1'b1;
        loaded_d   = 1'b0;
        load_d     = 1'b1;
        state_d    = ST_RUN;
        if (load_plane_q == PB'(BIT_DEPTH - 1)) begin
          load_plane_d = '0;
          load_row_d   = load_row_q + RB'(1);
        end else begin
          load_plane_d = load_plane_q + PB'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        load_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      load_q       <= 1'b0;
      loaded_q     <= 1'b0;
      load_row_q   <= '0;
      load_plane_q <= '0;
      row_addr_q   <= '0;
      blank_q      <= '0;
    end else begin
      state_q      <= state_d;
      load_q       <= load_d;
      loaded_q     <= loaded_d;
      load_row_q   <= load_row_d;
      load_plane_q <= load_plane_d;
      row_addr_q   <= row_addr_d;
      blank_q      <= blank_d;
    end
  end

  display_driver_bcm_timer #(
    .WIDTH(TB)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (timer_load),
    .value_i(timer_value),
    .busy_o (timer_busy)
  );

  assign load        = load_q;
  assign load_row    = load_row_q;
  assign load_plane  = load_plane_q;
  assign row_addr    = row_addr_q;
  assign latch       = (state_q == ST_LATCH);
  assign frame_start = latch && (load_row_q == '0) && (load_plane_q == '0);
  assign oe_n        = ~timer_busy;

endmodule
